// File: rtl/cpu_com_pkg.sv
// cpu_com_pkg: word-level CPU command protocol constants, error codes and host loader states
package cpu_com_pkg;
  localparam logic [31:0] CMD_RESET   = 32'd1;
  localparam logic [31:0] CMD_SEND_PC = 32'd2;
  localparam logic [31:0] RSP_READY   = 32'd3;
  typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_BAD_RSP, ERR_PC_RANGE} err_code_t;
  typedef enum logic [3:0] {
    S_IDLE, S_TX_RESET, S_WAIT_RDY, S_TX_PCREQ, S_WAIT_PC,
    S_FETCH, S_TX_INSTR, S_WAIT_ACK, S_DONE, S_ERROR
  } host_state_t;
  function automatic logic is_tx(host_state_t s);
    return s inside {S_TX_RESET, S_TX_PCREQ, S_TX_INSTR};
  endfunction
  function automatic logic is_wait(host_state_t s);
    return s inside {S_WAIT_RDY, S_WAIT_PC, S_WAIT_ACK};
  endfunction
endpackage

// File: rtl/cpu_com_host_loader_if.sv
// cpu_com_host_loader_if: word UART tx/rx and instruction memory signals of the host loader
//   tx_word/tx_start -> word UART tx, tx_done <- tx; rx_word/rx_valid <- word UART rx;
//   imem_addr -> instruction memory, imem_rdata <- memory (1-cycle synchronous read)
interface cpu_com_host_loader_if #(parameter int ADDR_W = 8);
  logic [31:0] tx_word;
  logic tx_start;
  logic tx_done;
  logic [31:0] rx_word;
  logic rx_valid;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_rdata;
  modport master(output tx_word, tx_start, imem_addr, input tx_done, rx_word, rx_valid, imem_rdata);
  modport slave(input tx_word, tx_start, imem_addr, output tx_done, rx_word, rx_valid, imem_rdata);
endinterface

// File: rtl/com_timeout_counter.sv
// com_timeout_counter: response watchdog down-counter
//   load reloads the budget, enable counts down, expired is high once the budget is used up.
//   Loading TIMEOUT-1 makes a state last exactly TIMEOUT cycles before expired is acted upon.
module com_timeout_counter #(parameter logic [31:0] TIMEOUT = 32'd5_000_000) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);
  logic [31:0] cnt;
  always_ff @(posedge clk)
    cnt <= reset ? '0 : load ? TIMEOUT - 32'd1 : (enable && cnt != '0) ? cnt - 32'd1 : cnt;
  assign expired = cnt == '0;
endmodule

// File: rtl/cpu_com_host_loader.sv
// cpu_com_host_loader: host-side initiator of the word-level CPU command protocol
//   clk, reset (sync, active-high); start pulse + num_instr steps to run;
//   bus: word UART tx/rx and imem port; busy/done/error status, err_code,
//   step_count (acked instructions), last_pc (last PC received).
module cpu_com_host_loader import cpu_com_pkg::*; #(
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] TIMEOUT = 32'd5_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           num_instr,
  cpu_com_host_loader_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output err_code_t             err_code,
  output logic [15:0]           step_count,
  output logic [31:0]           last_pc
);
  host_state_t state, nxt;
  logic entry, load, expired, rdy, pc_bad, accept, enable;
  logic [15:0] n_q, step_inc;
  logic [31:0] tx_q;
  assign rdy = bus.rx_word == RSP_READY;
  assign pc_bad = bus.rx_word[31:ADDR_W+2] != '0 || bus.rx_word[1:0] != 2'd0;
  assign step_inc = step_count == 16'hFFFF ? step_count : step_count + 16'd1;
  assign accept = start && !busy;
  assign enable = (is_tx(state) || is_wait(state)) && !load;
  // entry marks the first cycle spent in a state; it gates the one-shot tx_start
  always_ff @(posedge clk) begin
    state <= reset ? S_IDLE : nxt;
    entry <= !reset && nxt != state;
  end
  // a response arriving in the expiry cycle takes priority over the timeout
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: nxt = start ? S_TX_RESET : state;
      S_TX_RESET: nxt = bus.tx_done ? S_WAIT_RDY : expired ? S_ERROR : state;
      S_WAIT_RDY: nxt = bus.rx_valid ? (!rdy ? S_ERROR : step_count == n_q ? S_DONE : S_TX_PCREQ)
                                     : expired ? S_ERROR : state;
      S_TX_PCREQ: nxt = bus.tx_done ? S_WAIT_PC : expired ? S_ERROR : state;
      S_WAIT_PC:  nxt = bus.rx_valid ? (pc_bad ? S_ERROR : S_FETCH) : expired ? S_ERROR : state;
      S_FETCH:    nxt = S_TX_INSTR;
      S_TX_INSTR: nxt = bus.tx_done ? S_WAIT_ACK : expired ? S_ERROR : state;
      S_WAIT_ACK: nxt = bus.rx_valid ? (!rdy ? S_ERROR : step_inc == n_q ? S_DONE : S_TX_PCREQ)
                                     : expired ? S_ERROR : state;
      default:    nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy = !(state inside {S_IDLE, S_DONE, S_ERROR});
    done = state == S_DONE;
    error = state == S_ERROR;
    bus.tx_start = entry && is_tx(state);
    load = nxt != state && (is_tx(nxt) || is_wait(nxt));
  end
  // imem_rdata is only valid in the TX_INSTR entry cycle, so it is passed straight
  // through then and held in tx_q for the rest of the transmission
  assign bus.tx_word = (bus.tx_start && state == S_TX_INSTR) ? bus.imem_rdata : tx_q;
  assign bus.imem_addr = last_pc[ADDR_W+1:2];
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q <= '0;
      step_count <= '0;
      last_pc <= '0;
      err_code <= ERR_NONE;
      n_q <= '0;
    end else begin
      if (accept) begin
        step_count <= '0;
        err_code <= ERR_NONE;
        n_q <= num_instr;
      end
      if (load && nxt == S_TX_RESET) tx_q <= CMD_RESET;
      if (load && nxt == S_TX_PCREQ) tx_q <= CMD_SEND_PC;
      if (bus.tx_start && state == S_TX_INSTR) tx_q <= bus.imem_rdata;
      if (state == S_WAIT_PC && bus.rx_valid) last_pc <= bus.rx_word;
      if (state == S_WAIT_ACK && bus.rx_valid && rdy) step_count <= step_inc;
      if (nxt == S_ERROR && state != S_ERROR)
        err_code <= (state == S_WAIT_PC && bus.rx_valid) ? ERR_PC_RANGE :
                    (is_wait(state) && bus.rx_valid) ? ERR_BAD_RSP : ERR_TIMEOUT;
    end
  end
  com_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .reset(reset),
    .load(load),
    .enable(enable),
    .expired(expired)
  );
endmodule

// File: tb/tb_cpu_com_host_loader.sv
// tb_cpu_com_host_loader: directed scenarios against a transaction-level model of the loader
module tb_cpu_com_host_loader;
  import cpu_com_pkg::*;
  localparam int ADDR_W = 8;
  localparam int MEM_WORDS = 256;
  logic clk = 0, reset = 1, start = 0;
  logic [15:0] num_instr = 0;
  logic busy, done, error;
  err_code_t err_code;
  logic [15:0] step_count;
  logic [31:0] last_pc;
  cpu_com_host_loader_if #(.ADDR_W(ADDR_W)) bus();
  cpu_com_host_loader #(.ADDR_W(ADDR_W), .TIMEOUT(32'd100)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_instr(num_instr),
    .bus(bus.master),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .step_count(step_count),
    .last_pc(last_pc)
  );
  logic [31:0] mem [MEM_WORDS];
  int vecs = 0, fails = 0, cyc = 0, txn = 0, done_cyc = 0, end_cyc = 0, rdy_resp = 3;
  logic [31:0] pcq[$], rsp_q[$], exp_q[$];
  int m_err, m_steps;
  logic m_done, m_hang;
  logic [31:0] m_last = 0;
  logic in_tx = 0;
  logic [31:0] held;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask
  // model: what the host must transmit and how the run must end, from the protocol rules
  task automatic model(input int n, input int rdy);
    logic [31:0] pc;
    exp_q = {};
    exp_q.push_back(CMD_RESET);
    m_err = 0;
    m_steps = 0;
    m_hang = 0;
    if (rdy < 0) m_err = 1;
    else if (rdy != 3) m_err = 2;
    else
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(CMD_SEND_PC);
        if (i >= pcq.size()) begin
          m_hang = 1;
          break;
        end
        pc = pcq[i];
        m_last = pc;
        if (pc >= 32'(4 * MEM_WORDS) || pc[1:0] != 2'd0) begin
          m_err = 3;
          break;
        end
        exp_q.push_back(mem[pc[9:2]]);
        m_steps++;
      end
    m_done = m_err == 0 && !m_hang;
  endtask
  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial forever @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];
  // responder: word UART plus MCU-side controller
  initial begin
    logic [31:0] w, rw;
    logic have;
    bus.tx_done = 0;
    bus.rx_valid = 0;
    bus.rx_word = 0;
    @(negedge clk);
    forever begin
      if (bus.tx_start) begin
        w = bus.tx_word;
        txn++;
        repeat (3) @(negedge clk);
        bus.tx_done = 1;
        @(negedge clk);
        bus.tx_done = 0;
        done_cyc = cyc;
        have = 1;
        rw = RSP_READY;
        if (w == CMD_RESET) begin
          have = rdy_resp >= 0;
          rw = 32'(rdy_resp);
        end else if (w == CMD_SEND_PC) begin
          have = rsp_q.size() > 0;
          if (have) rw = rsp_q.pop_front();
        end
        if (have) begin
          repeat (2) @(negedge clk);
          bus.rx_word = rw;
          bus.rx_valid = 1;
          @(negedge clk);
          bus.rx_valid = 0;
        end
      end else @(negedge clk);
    end
  end
  // per-cycle compare: every transmitted word against the model, held stable until tx_done
  initial forever begin
    @(negedge clk);
    #1;
    if (reset) in_tx = 0;
    else begin
      chk("done_err_excl", 32'(done && error), 0);
      if (bus.tx_start) begin
        chk("tx_start_busy", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          vecs++;
          fails++;
          $display("FAIL tx_extra: got %h, want no word", bus.tx_word);
        end else chk("tx_word", bus.tx_word, exp_q.pop_front());
        held = bus.tx_word;
        in_tx = 1;
      end else if (in_tx) chk("tx_hold", bus.tx_word, held);
      if (bus.tx_done) in_tx = 0;
    end
  end
  task automatic run(input logic [15:0] n, input int rdy);
    rsp_q = pcq;
    rdy_resp = rdy;
    model(n, rdy);
    @(negedge clk);
    start = 1;
    num_instr = n;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_end(input string name);
    for (int k = 0; k < 1000 && !(done || error); k++) @(negedge clk);
    if (!(done || error)) begin
      vecs++;
      fails++;
      $display("FAIL %s_end: got busy, want done or error", name);
    end
    end_cyc = cyc;
  endtask
  task automatic final_chk(input string s);
    chk({s, "_done"}, 32'(done), 32'(m_done));
    chk({s, "_error"}, 32'(error), 32'(m_err != 0));
    chk({s, "_err_code"}, 32'(err_code), 32'(m_err));
    chk({s, "_steps"}, 32'(step_count), 32'(m_steps));
    chk({s, "_last_pc"}, last_pc, m_last);
    chk({s, "_busy"}, 32'(busy), 0);
    chk({s, "_all_tx"}, 32'(exp_q.size()), 0);
  endtask
  initial begin
    int base;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h5000_0000 + 32'(i) * 32'h0001_0101;
    mem[0] = 32'hAAAA_0001;
    mem[1] = 32'hBBBB_0002;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_tx_word", bus.tx_word, 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_steps", 32'(step_count), 0);
    chk("rst_last_pc", last_pc, 0);
    pcq = {};
    run(0, 3);
    wait_end("s1");
    final_chk("s1");
    chk("s1_done_lit", 32'(done), 1);
    pcq = {32'h0, 32'h4};
    run(2, 3);
    chk("s2_model_instr0", exp_q[2], 32'hAAAA_0001);
    chk("s2_model_instr1", exp_q[4], 32'hBBBB_0002);
    repeat (8) @(negedge clk);
    start = 1;
    num_instr = 9;
    @(negedge clk);
    start = 0;
    wait_end("s2");
    final_chk("s2");
    chk("s2_steps_lit", 32'(step_count), 2);
    pcq = {};
    run(2, 7);
    wait_end("s3");
    final_chk("s3");
    chk("s3_err_lit", 32'(err_code), 2);
    pcq = {32'h0000_1000};
    run(1, 3);
    wait_end("s4");
    final_chk("s4");
    chk("s4_err_lit", 32'(err_code), 3);
    chk("s4_pc_lit", last_pc, 32'h0000_1000);
    pcq = {32'h6};
    run(1, 3);
    wait_end("s5");
    final_chk("s5");
    pcq = {32'h3FC};
    run(1, 3);
    wait_end("s6");
    final_chk("s6");
    chk("s6_steps_lit", 32'(step_count), 1);
    pcq = {};
    run(1, -1);
    wait_end("s7");
    final_chk("s7");
    chk("s7_err_lit", 32'(err_code), 1);
    chk("s7_timeout_cycles", 32'(end_cyc - done_cyc), 100);
    pcq = {32'h0};
    base = txn;
    run(2, 3);
    for (int k = 0; k < 200 && txn < base + 4; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("s8_busy_wait_pc", 32'(busy), 1);
    chk("s8_steps_before", 32'(step_count), 1);
    chk("s8_sent_before", 32'(exp_q.size()), 0);
    reset = 1;
    @(negedge clk);
    chk("s8_rst_tx_start", 32'(bus.tx_start), 0);
    chk("s8_rst_busy", 32'(busy), 0);
    chk("s8_rst_steps", 32'(step_count), 0);
    chk("s8_rst_last_pc", last_pc, 0);
    @(negedge clk);
    reset = 0;
    m_last = 0;
    pcq = {32'h8};
    run(1, 3);
    wait_end("s8");
    final_chk("s8");
    chk("s8_steps_lit", 32'(step_count), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
